lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store sequencer between the core and the data-memory port. It accepts the decoder's memory controls (mem_req, mem_we, mem_size) plus the ALU address and rs2 data. It aligns store data and byte enables, runs a request/ready handshake with memory, and returns sign- or zero-extended load data. It holds core_stall_o high until the access completes so the PC and register file wait.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; only 32 is supported

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous reset, active-low
core_req_i  in  1  memory instruction present (decoder mem_req)
core_we_i  in  1  1 = store (decoder mem_we)
core_size_i  in  3  0=B 1=H 2=W 4=BU 5=HU (decoder mem_size)
core_addr_i  in  ADDR_W  byte address from ALU
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  extended load data; valid in DONE
core_stall_o  out  1  core must hold state and inputs
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  ADDR_W  word-aligned address
mem_wd_o  out  32  lane-replicated store data
mem_rd_i  in  32  memory read data, sampled with mem_ready_i
mem_ready_i  in  1  memory completes the current request
misalign_o  out  1  only with LSU_MISALIGN_TRAP_EN

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_ni.
- On reset: state=IDLE; every output is 0; internal latches are 0. Reset asserted mid-access aborts the access and drops mem_req_o immediately; there is no completion and no write-back.
- FSM states are IDLE, BUSY and DONE.
- IDLE: if core_req_i=1, latch we, size, addr[1:0], the word address, BE and aligned wd, then go to BUSY. Otherwise stay in IDLE.
- BUSY: mem_req_o=1, and mem_we_o/mem_be_o/mem_addr_o/mem_wd_o come from the latches.
  - If mem_ready_i=1 at a clock edge, capture the extended mem_rd_i into core_rd_o and go to DONE.
  - Otherwise stay in BUSY; there is no timeout.
- DONE: mem_req_o=0, then go to IDLE unconditionally. core_req_i still high in DONE belongs to the finished instruction and is not re-accepted.
- core_stall_o = core_req_i AND (state != DONE). Combinational, so it is high in the same cycle the request first appears.
- Latency: a zero-wait-state memory stalls the core for 2 cycles and releases it on the 3rd. Each extra wait cycle adds one stall cycle.
- Back-to-back memory instructions: the next request is accepted in the IDLE cycle after DONE.
- mem_ready_i outside BUSY is ignored.
- mem_addr_o = {addr[ADDR_W-1:2], 2'b00}.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0]
  - H/HU: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
- Store data:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- Load data:
  - Select the lane using addr[1:0], or addr[1] for halfwords.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Sizes 3, 6 and 7 are treated as W; the decoder has already flagged them as illegal.
- core_rd_o holds its value until the next load completes; stores do not change it.
- Misaligned access means H/HU with addr[0]=1, or W with addr[1:0]!=0. The default handling is in the Optional Feature section.

Optional Feature:
Macro name: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request in IDLE goes directly to DONE with no memory request.
  - misalign_o=1 for the DONE cycle only, and core_rd_o is set to 0.
  - The core stalls for 1 cycle.
- Undefined:
  - The misalign_o port is absent.
  - Misaligned accesses run truncated: the offset is forced to the natural boundary (H: addr[0]=0; W: addr[1:0]=0) for BE and lane select.

Decomposition:
- riscv_pkg gains:
  - size constants LDST_B/H/W/BU/HU
  - the typedef enum lsu_state_t {IDLE, BUSY, DONE}
- Sub-module lsu_align (combinational) computes BE, store replication and load extraction/extension from size and offset. lsu_ctrl owns the FSM and the latches.

Test Plan:
- SW addr=0x104, wd=0xDEADBEEF, mem_ready_i tied 1:
  - mem_req_o high 1 cycle, mem_addr_o=0x104, be=1111, wd=0xDEADBEEF
  - core_stall_o high 2 cycles
- SB addr=0x203, wd=0x000000A5 -> be=1000, mem_wd_o=0xA5A5A5A5.
- LB vs LBU at addr=0x302 with mem_rd_i=0x00F00000:
  - LB -> core_rd_o=0xFFFFFFF0
  - LBU -> core_rd_o=0x000000F0
  - LH at 0x302 -> 0x000000F0
- LW with mem_ready_i delayed 3 cycles -> mem_req_o high 4 cycles, core_stall_o high 5 cycles, data captured on the ready edge.
- rst_ni pulled low while in BUSY -> mem_req_o=0 and core_stall_o=0 asynchronously; after release, state is IDLE and core_rd_o=0.
- LW addr=0x101:
  - LSU_MISALIGN_TRAP_EN defined -> no mem_req_o, misalign_o pulse, 1 stall cycle.
  - Undefined -> access to 0x100 with be=1111.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the load/store unit.
// Holds the decoder's mem_size encodings, the LSU state type and
// small decode helpers for access width, signedness and alignment.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Byte access: signed or unsigned.
    function automatic logic size_is_byte(input logic [2:0] size);
        return (size == LDST_B) || (size == LDST_BU);
    endfunction

    // Halfword access: signed or unsigned.
    function automatic logic size_is_half(input logic [2:0] size);
        return (size == LDST_H) || (size == LDST_HU);
    endfunction

    // Loads that sign-extend their result.
    function automatic logic size_is_signed(input logic [2:0] size);
        return (size == LDST_B) || (size == LDST_H);
    endfunction

    // Anything that is neither byte nor halfword (including the illegal
    // encodings 3, 6 and 7) is handled as a full word.
    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (size_is_half(size)) begin
            mis = offset[0];
        end else if (!size_is_byte(size)) begin
            mis = (offset != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Produces byte enables and lane-replicated store data for the outgoing
// access, and selects/extends the returned word for loads. Misaligned
// offsets are forced down to the natural boundary of the access size.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [1:0]  eff_off;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Snap the offset to the access boundary, then derive BE and store lanes.
    always_comb begin
        eff_off     = 2'b00;
        byte_en     = 4'b1111;
        store_lanes = store_data;
        if (size_is_byte(size)) begin
            eff_off     = offset;
            byte_en     = 4'b0001 << eff_off;
            store_lanes = {4{store_data[7:0]}};
        end else if (size_is_half(size)) begin
            eff_off     = {offset[1], 1'b0};
            byte_en     = 4'b0011 << eff_off;
            store_lanes = {2{store_data[15:0]}};
        end
    end

    // Pick the addressed lane from the memory word and extend it to 32 bits.
    always_comb begin
        load_byte = load_word[{eff_off, 3'b000} +: 8];
        load_half = load_word[{eff_off[1], 4'b0000} +: 16];
        load_data = load_word;
        if (size_is_byte(size)) begin
            if (size_is_signed(size)) begin
                load_data = {{24{load_byte[7]}}, load_byte};
            end else begin
                load_data = {24'h000000, load_byte};
            end
        end else if (size_is_half(size)) begin
            if (size_is_signed(size)) begin
                load_data = {{16{load_half[15]}}, load_half};
            end else begin
                load_data = {16'h0000, load_half};
            end
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the core and the data-memory port.
// Latches the decoder's memory controls, runs a req/ready handshake with
// memory, returns extended load data and stalls the core meanwhile.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses skip
// memory and pulse misalign_o instead of running truncated.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    lsu_state_t        state_q, state_d;

    logic              we_q;
    logic [2:0]        size_q;
    logic [1:0]        off_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;
    logic [31:0]       rd_q;

    logic              take_req;
    logic              busy;
    logic [2:0]        align_size;
    logic [1:0]        align_off;
    logic [3:0]        align_be;
    logic [31:0]       align_wd;
    logic [31:0]       align_rd;

`ifdef LSU_MISALIGN_TRAP_EN
    logic              mis_req;
    logic              mis_q;

    assign mis_req = is_misaligned(core_size_i, core_addr_i[1:0]);
`endif

    assign take_req = (state_q == IDLE) && core_req_i;
    assign busy     = (state_q == BUSY);

    // In IDLE the lane logic works on the incoming request so BE and store
    // data can be latched; afterwards it works on the latched access so the
    // returning load word is decoded with the original size and offset.
    assign align_size = (state_q == IDLE) ? core_size_i      : size_q;
    assign align_off  = (state_q == IDLE) ? core_addr_i[1:0] : off_q;

    lsu_align u_align (
        .size        (align_size),
        .offset      (align_off),
        .store_data  (core_wd_i),
        .load_word   (mem_rd_i),
        .byte_en     (align_be),
        .store_lanes (align_wd),
        .load_data   (align_rd)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, wait for ready in BUSY, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = mis_req ? DONE : BUSY;
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request attributes when a new access is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            off_q   <= 2'd0;
            waddr_q <= '0;
            be_q    <= 4'd0;
            wd_q    <= 32'd0;
        end else if (take_req) begin
            we_q    <= core_we_i;
            size_q  <= core_size_i;
            off_q   <= core_addr_i[1:0];
            waddr_q <= core_addr_i[ADDR_W-1:2];
            be_q    <= align_be;
            wd_q    <= align_wd;
        end
    end

    // Load result register; only a completing load (or a trapped access) changes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= 32'd0;
        end else if (busy && mem_ready_i && !we_q) begin
            rd_q <= align_rd;
`ifdef LSU_MISALIGN_TRAP_EN
        end else if (take_req && mis_req) begin
            rd_q <= 32'd0;
`endif
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Remember whether the accepted access was a misalignment trap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q <= 1'b0;
        end else if (take_req) begin
            mis_q <= mis_req;
        end
    end

    assign misalign_o = (state_q == DONE) && mis_q;
`endif

    // Memory port is driven only while BUSY; the stall is released in DONE
    // and forced low while reset is asserted.
    always_comb begin
        core_stall_o = rst_ni && core_req_i && (state_q != DONE);
        mem_req_o    = busy;
        mem_we_o     = busy && we_q;
        mem_be_o     = busy ? be_q : 4'd0;
        mem_addr_o   = busy ? {waddr_q, 2'b00} : '0;
        mem_wd_o     = busy ? wd_q : '0;
        core_rd_o    = rd_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a scoreboard of expected memory
// requests and load results. Works with and without LSU_MISALIGN_TRAP_EN.
module tb_lsu_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'd0;
    logic [31:0] core_wd = 32'd0;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = 32'd0;
    logic        mem_ready = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } mem_exp_t;

    mem_exp_t    mem_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rd = 32'd0;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign)
`endif
    );

    always #5 clk = ~clk;

    // Reference model of the access semantics.
    function automatic bit m_byte(input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd4);
    endfunction

    function automatic bit m_half(input logic [2:0] s);
        return (s == 3'd1) || (s == 3'd5);
    endfunction

    function automatic logic [1:0] m_off(input logic [2:0] s, input logic [31:0] a);
        if (m_byte(s)) return a[1:0];
        if (m_half(s)) return {a[1], 1'b0};
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
        if (m_byte(s)) return 4'b0001 << m_off(s, a);
        if (m_half(s)) return 4'b0011 << m_off(s, a);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] d);
        if (m_byte(s)) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (m_half(s)) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a,
                                           input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> (8 * int'(m_off(s, a)));
        if (m_byte(s)) return (s == 3'd0 && sh[7])  ? (32'hFFFFFF00 | sh[7:0])  : {24'd0, sh[7:0]};
        if (m_half(s)) return (s == 3'd1 && sh[15]) ? (32'hFFFF0000 | sh[15:0]) : {16'd0, sh[15:0]};
        return d;
    endfunction

    function automatic bit m_mis(input logic [2:0] s, input logic [31:0] a);
        if (m_byte(s)) return 1'b0;
        if (m_half(s)) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    // Drive one access, play the memory, and score requests, stall length and result.
    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rdata,
                             input int wait_cycles, input string name);
        mem_exp_t    e, g;
        logic [31:0] exp_rd;
        bit          mis, seen, done;
        int          stall_n, req_n, exp_stall, exp_req;
        seen = 0; done = 0; stall_n = 0; req_n = 0;
        mis = TRAP && m_mis(size, addr);
        if (!mis) begin
            e.we   = we;
            e.addr = {addr[31:2], 2'b00};
            e.be   = m_be(size, addr);
            e.wd   = we ? m_wd(size, wd) : 32'd0;
            mem_q.push_back(e);
        end
        if (mis) last_rd = 32'd0;
        else if (!we) last_rd = m_load(size, addr, rdata);
        rd_q.push_back(last_rd);
        exp_stall = mis ? 1 : wait_cycles + 2;
        exp_req   = mis ? 0 : wait_cycles + 1;

        @(negedge clk);
        core_req  = 1'b1;
        core_we   = we;
        core_size = size;
        core_addr = addr;
        core_wd   = wd;
        mem_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (mem_req) begin
                req_n++;
                if (!seen) begin
                    seen = 1;
                    chk_cnt++;
                    if (mem_q.size() == 0) begin
                        $display("[TB] FAIL %s unexpected_req: got addr=%h, required no request", name, mem_addr);
                    end else begin
                        e = mem_q.pop_front();
                        g.we = mem_we; g.addr = mem_addr; g.be = mem_be; g.wd = we ? mem_wd : 32'd0;
                        if (g.we !== e.we || g.addr !== e.addr || g.be !== e.be || g.wd !== e.wd) begin
                            $display("[TB] FAIL %s mem_req: got we=%b addr=%h be=%b wd=%h, required we=%b addr=%h be=%b wd=%h",
                                     name, g.we, g.addr, g.be, g.wd, e.we, e.addr, e.be, e.wd);
                        end else begin
                            pass_cnt++;
                        end
                    end
                end
                if (req_n == wait_cycles + 1) begin
                    mem_ready = 1'b1;
                    mem_rd    = rdata;
                end else begin
                    mem_ready = 1'b0;
                    mem_rd    = $urandom;
                end
            end else begin
                mem_ready = 1'b0;
            end
            if (core_stall) begin
                stall_n++;
            end else begin
                done = 1;
                exp_rd = rd_q.pop_front();
                chk_cnt++;
                if (core_rd !== exp_rd) $display("[TB] FAIL %s core_rd: got %h, required %h", name, core_rd, exp_rd);
                else pass_cnt++;
`ifdef LSU_MISALIGN_TRAP_EN
                chk_cnt++;
                if (misalign !== mis) $display("[TB] FAIL %s misalign: got %b, required %b", name, misalign, mis);
                else pass_cnt++;
`endif
            end
            if (!done) @(negedge clk);
        end
        if (!done) begin
            void'(rd_q.pop_front());
            chk_cnt++;
            $display("[TB] FAIL %s timeout: got no completion in 40 cycles, required completion", name);
        end
        if (!seen && !mis && mem_q.size() > 0) void'(mem_q.pop_front());
        chk_cnt++;
        if (stall_n !== exp_stall) $display("[TB] FAIL %s stall_cycles: got %0d, required %0d", name, stall_n, exp_stall);
        else pass_cnt++;
        chk_cnt++;
        if (req_n !== exp_req) $display("[TB] FAIL %s req_cycles: got %0d, required %0d", name, req_n, exp_req);
        else pass_cnt++;
    endtask

    // Drop the request after DONE and confirm it is not accepted again.
    task automatic go_idle(input string name);
        @(negedge clk);
        core_req = 1'b0;
        #1;
        chk_cnt++;
        if (mem_req !== 1'b0 || core_stall !== 1'b0)
            $display("[TB] FAIL %s idle_after_done: got req=%b stall=%b, required 0 0", name, mem_req, core_stall);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        core_req = 1'b1;
        #2;
        chk_cnt++;
        if (core_stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'd0 ||
            mem_addr !== 32'd0 || mem_wd !== 32'd0 || core_rd !== 32'd0)
            $display("[TB] FAIL reset_outputs: got stall=%b req=%b we=%b be=%b addr=%h wd=%h rd=%h, required all 0",
                     core_stall, mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd);
        else pass_cnt++;
        @(negedge clk);
        core_req = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_store_word();
        do_access(1'b1, LDST_W, 32'h104, 32'hDEADBEEF, 32'h0, 0, "sw");
        go_idle("sw");
    endtask

    task automatic test_store_byte();
        do_access(1'b1, LDST_B, 32'h203, 32'h000000A5, 32'h0, 0, "sb");
        go_idle("sb");
    endtask

    task automatic test_back_to_back_loads();
        do_access(1'b0, LDST_B,  32'h302, 32'h0, 32'h00F00000, 0, "lb");
        do_access(1'b0, LDST_BU, 32'h302, 32'h0, 32'h00F00000, 0, "lbu");
        do_access(1'b0, LDST_H,  32'h302, 32'h0, 32'h00F00000, 0, "lh");
        do_access(1'b0, LDST_H,  32'h300, 32'h0, 32'h1234ABCD, 1, "lh_neg");
        do_access(1'b0, LDST_HU, 32'h302, 32'h0, 32'h9ABC0000, 0, "lhu");
        go_idle("loads");
    endtask

    task automatic test_wait_states();
        do_access(1'b0, LDST_W, 32'h400, 32'h0, 32'h12345678, 3, "lw_wait3");
        go_idle("lw_wait3");
    endtask

    task automatic test_store_keeps_rd();
        do_access(1'b1, LDST_H, 32'h502, 32'h0000BEEF, 32'h0, 2, "sh_keep_rd");
        go_idle("sh_keep_rd");
    endtask

    task automatic test_legacy_size();
        do_access(1'b0, 3'd3, 32'h608, 32'h0, 32'h80000001, 0, "size3_as_w");
        do_access(1'b1, 3'd7, 32'h60C, 32'h11223344, 32'h0, 0, "size7_as_w");
        go_idle("legacy");
    endtask

    task automatic test_misalign();
        do_access(1'b0, LDST_W, 32'h101, 32'h0, 32'hCAFEF00D, 0, "lw_mis");
        do_access(1'b0, LDST_H, 32'h103, 32'h0, 32'h8001ABCD, 0, "lh_mis");
        go_idle("misalign");
    endtask

    task automatic test_ready_outside_busy();
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rd    = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_cnt++;
            if (mem_req !== 1'b0 || core_rd !== last_rd)
                $display("[TB] FAIL stray_ready: got req=%b rd=%h, required req=0 rd=%h", mem_req, core_rd, last_rd);
            else pass_cnt++;
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = LDST_W;
        core_addr = 32'h500;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk_cnt++;
        if (mem_req !== 1'b1) $display("[TB] FAIL busy_before_reset: got req=%b, required 1", mem_req);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (mem_req !== 1'b0 || core_stall !== 1'b0)
            $display("[TB] FAIL async_abort: got req=%b stall=%b, required 0 0", mem_req, core_stall);
        else pass_cnt++;
        @(negedge clk);
        rst_n    = 1'b1;
        core_req = 1'b0;
        last_rd  = 32'd0;
        #1;
        chk_cnt++;
        if (mem_req !== 1'b0 || core_rd !== 32'd0)
            $display("[TB] FAIL after_reset: got req=%b rd=%h, required 0 00000000", mem_req, core_rd);
        else pass_cnt++;
        do_access(1'b0, LDST_BU, 32'h701, 32'h0, 32'h0000C300, 0, "lbu_after_reset");
        go_idle("after_reset");
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_byte();
        test_back_to_back_loads();
        test_wait_states();
        test_store_keeps_rd();
        test_legacy_size();
        test_misalign();
        test_ready_outside_busy();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
